// File: rtl/ex_muldiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer.
package ex_muldiv_seq_pkg;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'b000,
    MULDIV_MULH   = 3'b001,
    MULDIV_MULHSU = 3'b010,
    MULDIV_MULHU  = 3'b011,
    MULDIV_DIV    = 3'b100,
    MULDIV_DIVU   = 3'b101,
    MULDIV_REM    = 3'b110,
    MULDIV_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCalc  = 2'd1,
    StFixup = 2'd2,
    StDone  = 2'd3
  } muldiv_state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(logic [2:0] op);
    return (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
           (op == MULDIV_DIV)  || (op == MULDIV_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM only.
  function automatic logic op_signed_b(logic [2:0] op);
    return (op == MULDIV_MULH) || (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

  // Result of a special case: multiply by zero, divide by zero, or signed overflow.
  function automatic logic [31:0] special_result(logic [2:0] op, logic [31:0] a, logic div0);
    if (!op[2]) return ZERO_WORD;
    if (div0)   return op[1] ? a : DIV0_QUOT;
    return op[1] ? ZERO_WORD : INT_MIN;
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
module muldiv_step (
  input  logic        is_div,
  input  logic [63:0] acc_in,
  input  logic [31:0] operand,   // multiplicand or divisor
  input  logic        bit_in,    // multiplier LSB or next dividend bit
  output logic [63:0] acc_out
);

  logic [32:0] sum;
  logic [33:0] trial;
  logic        borrow;
  logic [31:0] rem_next;
  logic        unused_trial;

  // Multiply adds into the upper half then shifts right; divide shifts left and trial-subtracts.
  always_comb begin
    sum      = {1'b0, acc_in[63:32]} + (bit_in ? {1'b0, operand} : 33'd0);
    trial    = {1'b0, acc_in[63:32], bit_in} - {2'b00, operand};
    borrow   = trial[33];
    // Without borrow the difference is below the divisor, so it fits in 32 bits.
    rem_next = borrow ? {acc_in[62:32], bit_in} : trial[31:0];
    acc_out  = is_div ? {rem_next, acc_in[30:0], ~borrow} : {sum, acc_in[31:1]};
  end

  assign unused_trial = trial[32];

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Optional macro MULDIV_FAST_EN: trivial multiplies and special-case divides finish in one cycle.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic             div0_q, div0_d, ovf_q, ovf_d;
  logic [31:0]      mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [31:0]      a_raw_q, a_raw_d;
  logic [31:0]      result_q, result_d;
  logic [63:0]      acc_q, acc_d;

  logic        sa_in, sb_in, div0_in, ovf_in;
  logic [63:0] step_out;
  logic [63:0] prod;
  logic [31:0] quot, rem, fix_res;
`ifdef MULDIV_FAST_EN
  logic        fast_hit;
`endif

  muldiv_step u_step (
    .is_div  (op_q[2]),
    .acc_in  (acc_q),
    .operand (op_q[2] ? mag_b_q : mag_a_q),
    .bit_in  (op_q[2] ? mag_a_q[31] : mag_b_q[0]),
    .acc_out (step_out)
  );

  // Operand classification at the moment a start is accepted.
  always_comb begin
    sa_in   = op_signed_a(op) & dataA[XLEN-1];
    sb_in   = op_signed_b(op) & dataB[XLEN-1];
    div0_in = (dataB == ZERO_WORD);
    ovf_in  = op[2] && !op[0] && (dataA == INT_MIN) && (dataB == DIV0_QUOT);
`ifdef MULDIV_FAST_EN
    fast_hit = op[2] ? (div0_in || ovf_in) : ((dataA == ZERO_WORD) || div0_in);
`endif
  end

  // Sign and special-case correction of the raw product or quotient/remainder.
  always_comb begin
    prod = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
    quot = (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0];
    rem  = sa_q ? -acc_q[63:32] : acc_q[63:32];
    if (op_q[2]) begin
      if (div0_q || ovf_q) fix_res = special_result(op_q, a_raw_q, div0_q);
      else                 fix_res = op_q[1] ? rem : quot;
    end else begin
      fix_res = (op_q == MULDIV_MUL) ? prod[31:0] : prod[63:32];
    end
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    a_raw_d  = a_raw_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d    = op;
          sa_d    = sa_in;
          sb_d    = sb_in;
          div0_d  = div0_in;
          ovf_d   = ovf_in;
          mag_a_d = sa_in ? -dataA : dataA;
          mag_b_d = sb_in ? -dataB : dataB;
          a_raw_d = dataA;
          acc_d   = 64'd0;
          cnt_d   = '0;
          state_d = StCalc;
`ifdef MULDIV_FAST_EN
          if (fast_hit) begin
            result_d = special_result(op, dataA, div0_in);
            state_d  = StDone;
          end
`endif
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = step_out;
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q[2]) mag_a_d = {mag_a_q[30:0], 1'b0};
          else         mag_b_d = {1'b0, mag_b_q[31:1]};
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = StFixup;
        end
      end
      StFixup: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          result_d = fix_res;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= 3'b000;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mag_a_q  <= ZERO_WORD;
      mag_b_q  <= ZERO_WORD;
      a_raw_q  <= ZERO_WORD;
      acc_q    <= 64'd0;
      result_q <= ZERO_WORD;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      a_raw_q  <= a_raw_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Handshake outputs.
  always_comb begin
    busy   = (state_q == StCalc) || (state_q == StFixup);
    stall  = (start && (state_q == StIdle) && !flush) || busy;
    done   = (state_q == StDone);
    result = result_q;
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed testbench for ex_muldiv_seq; honours MULDIV_FAST_EN for special-case latency.
module tb_ex_muldiv_seq;
  import ex_muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] dataA, dataB;
  logic        busy, stall, done;
  logic [31:0] result;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_res;

`ifdef MULDIV_FAST_EN
  localparam int SpLat = 1;
`else
  localparam int SpLat = 34;
`endif
  localparam int Lat = 34;

  ex_muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .dataA  (dataA),
    .dataB  (dataB),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start an op in the current cycle (cycle 0) and follow it until cycle lat.
  // With inj set, a conflicting start is presented in cycle 5.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit inj);
    int          done_cnt  = 0;
    int          done_cyc  = -1;
    logic        stall_bad = 1'b0;
    logic [31:0] res_at    = 32'h0;
    start = 1'b1;
    op    = o;
    dataA = a;
    dataB = b;
    for (int cyc = 0; cyc <= lat; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check({tag, " busy0"}, 32'(busy), 32'h0);
        check({tag, " hold"}, result, last_res);
      end
      if (stall !== (cyc < lat)) stall_bad = 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        res_at   = result;
      end
      @(posedge clk);
      #1;
      if (inj && cyc == 4) begin
        start = 1'b1;
        op    = MULDIV_MULHU;
        dataA = 32'h1234_5678;
        dataB = 32'h0000_0100;
      end else begin
        start = 1'b0;
        dataA = ~a;
        dataB = a ^ b;
      end
    end
    check({tag, " result"}, res_at, exp);
    check({tag, " done_cyc"}, 32'(done_cyc), 32'(lat));
    check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, " stall"}, 32'(stall_bad), 32'h0);
    last_res = exp;
  endtask

  // Start DIVU, then kill it with flush or reset in cycle 10; returns in cycle 11.
  task automatic abort_op(input string tag, input bit use_rst);
    int dcnt = 0;
    start = 1'b1;
    op    = MULDIV_DIVU;
    dataA = 32'd100;
    dataB = 32'd7;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c == 9) begin
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
      end
    end
    rst   = 1'b0;
    flush = 1'b0;
    check({tag, " no_done"}, 32'(dcnt), 32'h0);
    if (use_rst) last_res = ZERO_WORD;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'b000;
    dataA = 32'h0;
    dataB = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst busy", 32'(busy), 32'h0);
    check("rst done", 32'(done), 32'h0);
    check("rst stall", 32'(stall), 32'h0);
    check("rst result", result, 32'h0);
    @(posedge clk);
    #1;
    last_res = ZERO_WORD;

    run_op("mul 7x6",      MULDIV_MUL,    32'd7,         32'd6,         32'h0000_002A, Lat, 1'b0);
    run_op("mul -1x2",     MULDIV_MUL,    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, Lat, 1'b0);
    run_op("mulh min^2",   MULDIV_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, Lat, 1'b0);
    run_op("mulhu max^2",  MULDIV_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, Lat, 1'b0);
    run_op("mulhsu",       MULDIV_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, Lat, 1'b0);
    run_op("div -7/2",     MULDIV_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, Lat, 1'b0);
    run_op("rem -7/2",     MULDIV_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, Lat, 1'b0);
    run_op("divu 100/7",   MULDIV_DIVU,   32'd100,       32'd7,         32'h0000_000E, Lat, 1'b0);
    run_op("remu 100/7",   MULDIV_REMU,   32'd100,       32'd7,         32'h0000_0002, Lat, 1'b0);
    run_op("div 5/0",      MULDIV_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, SpLat, 1'b0);
    run_op("remu 5/0",     MULDIV_REMU,   32'd5,         32'd0,         32'h0000_0005, SpLat, 1'b0);
    run_op("div ovf",      MULDIV_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpLat, 1'b0);
    run_op("rem ovf",      MULDIV_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SpLat, 1'b0);
    run_op("mul 0x5",      MULDIV_MUL,    32'd0,         32'd5,         32'h0000_0000, SpLat, 1'b0);
    run_op("rem -9/4",     MULDIV_REM,    32'hFFFF_FFF7, 32'd4,         32'hFFFF_FFFF, Lat, 1'b0);

    // start together with flush in IDLE must not be accepted
    start = 1'b1;
    flush = 1'b1;
    op    = MULDIV_DIVU;
    dataA = 32'd9;
    dataB = 32'd3;
    @(negedge clk);
    check("idle flush stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("idle flush busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;

    abort_op("flush", 1'b0);
    run_op("after flush",  MULDIV_DIVU,   32'd100,       32'd7,         32'h0000_000E, Lat, 1'b0);
    abort_op("reset", 1'b1);
    run_op("after reset",  MULDIV_MUL,    32'd7,         32'd6,         32'h0000_002A, Lat, 1'b0);

    // conflicting start mid-run is ignored; the next start is back-to-back in cycle 35
    run_op("ignore start", MULDIV_MULHU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, Lat, 1'b1);
    run_op("back2back",    MULDIV_REMU,   32'd1000,      32'd33,        32'h0000_000A, Lat, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
